// File: rtl/ex_wb_arbiter_pkg.sv
// Shared constants and helpers for the execute-to-writeback arbiter.
// Optional round-robin policy is selected with EX_WB_RR_EN.
package ex_wb_arbiter_pkg;

  localparam int NUM_REQ_DEF = 3;
  localparam int XLEN_DEF    = 32;
  localparam int REG_AW_DEF  = 5;

  // Producer slot indices; lower index wins under fixed priority.
  typedef enum int {
    REQ_ALU = 0,
    REQ_LSU = 1,
    REQ_CSR = 2
  } req_id_e;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ex_wb_arbiter_if.sv
// Producer request bundle plus registered write port and pending-destination mask.
import ex_wb_arbiter_pkg::*;

interface ex_wb_arbiter_if #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int XLEN    = XLEN_DEF,
  parameter int REG_AW  = REG_AW_DEF
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*REG_AW-1:0] req_rd;
  logic [NUM_REQ*XLEN-1:0]   req_data;
  logic                      wb_en;
  logic [REG_AW-1:0]         wb_rd;
  logic [XLEN-1:0]           wb_data;
  logic [2**REG_AW-1:0]      pend_mask;

  modport master (
    output req_valid, req_rd, req_data,
    input  req_ready, wb_en, wb_rd, wb_data, pend_mask
  );

  modport slave (
    input  req_valid, req_rd, req_data,
    output req_ready, wb_en, wb_rd, wb_data, pend_mask
  );

endinterface

// File: rtl/ex_wb_arbiter_arb.sv
// One-hot grant over full slots: round-robin from ptr when EX_WB_RR_EN is
// defined, otherwise fixed priority with the lowest index winning.
module wb_arbiter
  import ex_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
`ifdef EX_WB_RR_EN
  , parameter int PTR_W = 2
`endif
) (
  input  logic [NUM_REQ-1:0] req,
`ifdef EX_WB_RR_EN
  input  logic [PTR_W-1:0]   ptr,
`endif
  output logic [NUM_REQ-1:0] grant
);

  logic found;

`ifdef EX_WB_RR_EN
  int idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = int'(ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
      idx = wrap_inc(idx, NUM_REQ);
    end
  end
`else
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ex_wb_arbiter.sv
// Per-producer holding slots drained one per cycle into a registered write port.
// Arbitration policy: round-robin with EX_WB_RR_EN defined, fixed priority otherwise.
module ex_wb_arbiter
  import ex_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int XLEN    = XLEN_DEF,
  parameter int REG_AW  = REG_AW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  ex_wb_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] full_reg;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] accept;
  logic [REG_AW-1:0]  rd_reg   [NUM_REQ];
  logic [XLEN-1:0]    data_reg [NUM_REQ];

  logic               wb_en_reg;
  logic [REG_AW-1:0]  wb_rd_reg;
  logic [XLEN-1:0]    wb_data_reg;

  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic [2**REG_AW-1:0] pend_mask_next;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      logic [REG_AW-1:0] rd_in;
      logic [XLEN-1:0]   data_in;

      assign rd_in   = bus.req_rd[gi*REG_AW +: REG_AW];
      assign data_in = bus.req_data[gi*XLEN +: XLEN];

      // A granted slot may be refilled on the same edge it drains.
      assign bus.req_ready[gi] = !full_reg[gi] | grant[gi];
      assign accept[gi]        = bus.req_valid[gi] & bus.req_ready[gi];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          full_reg[gi] <= 1'b0;
          rd_reg[gi]   <= '0;
          data_reg[gi] <= '0;
        end else if (accept[gi]) begin
          // Writes to x0 complete the handshake but never occupy the slot.
          full_reg[gi] <= (rd_in != '0);
          rd_reg[gi]   <= rd_in;
          data_reg[gi] <= data_in;
        end else if (grant[gi]) begin
          full_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

`ifdef EX_WB_RR_EN
  logic [PTR_W-1:0] ptr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= '0;
    end else if (grant_any) begin
      ptr_reg <= PTR_W'(wrap_inc(int'(grant_idx), NUM_REQ));
    end
  end

  wb_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (full_reg),
    .ptr   (ptr_reg),
    .grant (grant)
  );
`else
  wb_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (full_reg),
    .grant (grant)
  );
`endif

  always_comb begin
    grant_idx = '0;
    grant_any = |grant;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = PTR_W'(i);
      end
    end
  end

  // Write data holds its last value while the strobe is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_reg   <= 1'b0;
      wb_rd_reg   <= '0;
      wb_data_reg <= '0;
    end else begin
      wb_en_reg <= grant_any;
      if (grant_any) begin
        wb_rd_reg   <= rd_reg[grant_idx];
        wb_data_reg <= data_reg[grant_idx];
      end
    end
  end

  always_comb begin
    pend_mask_next = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (full_reg[i]) begin
        pend_mask_next[rd_reg[i]] = 1'b1;
      end
    end
    if (wb_en_reg) begin
      pend_mask_next[wb_rd_reg] = 1'b1;
    end
    pend_mask_next[0] = 1'b0;
  end

  assign bus.wb_en     = wb_en_reg;
  assign bus.wb_rd     = wb_rd_reg;
  assign bus.wb_data   = wb_data_reg;
  assign bus.pend_mask = pend_mask_next;

endmodule

// File: tb/tb_ex_wb_arbiter.sv
// Directed bench for ex_wb_arbiter; expectations switch with EX_WB_RR_EN.
`timescale 1ns/1ps
module tb_ex_wb_arbiter;
  import ex_wb_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  ex_wb_arbiter_if #(.NUM_REQ(3), .XLEN(32), .REG_AW(5)) bus ();

  ex_wb_arbiter #(.NUM_REQ(3), .XLEN(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-18s = %0h", tag, got);
    end else begin
      $display("FAIL %-18s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.req_valid[i]        = v;
    bus.req_rd[i*5 +: 5]    = rd;
    bus.req_data[i*32 +: 32] = d;
  endtask

  task automatic idle();
    bus.req_valid = '0;
  endtask

  int          t2_rd [3];
  logic [31:0] t2_pend [3];
  logic        early_exp;
  logic        pend10_exp;
  int          last_rd_exp;
  int          nwrites;
  int          load_writes;
  logic        early;
  int          writes;

  initial begin
    n_checks = 0;
    n_pass   = 0;
`ifdef EX_WB_RR_EN
    t2_rd   = '{2, 3, 1};
    t2_pend = '{32'hE, 32'hA, 32'h2};
    early_exp   = 1'b1;
    pend10_exp  = 1'b0;
    last_rd_exp = 1;
`else
    t2_rd   = '{1, 2, 3};
    t2_pend = '{32'hE, 32'hC, 32'h8};
    early_exp   = 1'b0;
    pend10_exp  = 1'b1;
    last_rd_exp = 3;
`endif
    rst          = 1'b0;
    bus.req_valid = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_wb_en",   64'(bus.wb_en), 64'(0));
    chk("rst_wb_rd",   64'(bus.wb_rd), 64'(0));
    chk("rst_wb_data", 64'(bus.wb_data), 64'(0));
    chk("rst_pend",    64'(bus.pend_mask), 64'(0));
    chk("rst_ready",   64'(bus.req_ready), 64'(3'b111));
    rst = 1'b1;
    @(negedge clk);

    // Single ALU beat, two-cycle latency
    drive(REQ_ALU, 1'b1, 5'd5, 32'h1234);
    @(negedge clk);
    idle();
    chk("t1_held_wb_en", 64'(bus.wb_en), 64'(0));
    chk("t1_held_pend",  64'(bus.pend_mask), 64'(32'h20));
    @(negedge clk);
    chk("t1_wb_en",   64'(bus.wb_en), 64'(1));
    chk("t1_wb_rd",   64'(bus.wb_rd), 64'(5));
    chk("t1_wb_data", 64'(bus.wb_data), 64'(32'h1234));
    chk("t1_pend",    64'(bus.pend_mask), 64'(32'h20));
    @(negedge clk);
    chk("t1_done_wb_en", 64'(bus.wb_en), 64'(0));
    chk("t1_done_pend",  64'(bus.pend_mask), 64'(0));
    chk("t1_hold_rd",    64'(bus.wb_rd), 64'(5));

    // All three producers on one edge
    drive(REQ_ALU, 1'b1, 5'd1, 32'h101);
    drive(REQ_LSU, 1'b1, 5'd2, 32'h102);
    drive(REQ_CSR, 1'b1, 5'd3, 32'h103);
    chk("t2_ready", 64'(bus.req_ready), 64'(3'b111));
    @(negedge clk);
    idle();
    chk("t2_pend_full", 64'(bus.pend_mask), 64'(32'hE));
    chk("t2_wb_en_0",   64'(bus.wb_en), 64'(0));
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("t2_wb_en%0d", j),   64'(bus.wb_en), 64'(1));
      chk($sformatf("t2_wb_rd%0d", j),   64'(bus.wb_rd), 64'(t2_rd[j]));
      chk($sformatf("t2_wb_data%0d", j), 64'(bus.wb_data), 64'(32'h100 + t2_rd[j]));
      chk($sformatf("t2_pend%0d", j),    64'(bus.pend_mask), 64'(t2_pend[j]));
    end
    @(negedge clk);
    chk("t2_done_wb_en", 64'(bus.wb_en), 64'(0));
    chk("t2_done_pend",  64'(bus.pend_mask), 64'(0));

    // Write to x0 is accepted and discarded
    drive(REQ_LSU, 1'b1, 5'd0, 32'hFFFF);
    chk("t4_ready", 64'(bus.req_ready[REQ_LSU]), 64'(1));
    @(negedge clk);
    idle();
    chk("t4_pend",  64'(bus.pend_mask), 64'(0));
    chk("t4_wb_en", 64'(bus.wb_en), 64'(0));
    @(negedge clk);
    chk("t4_wb_en2",  64'(bus.wb_en), 64'(0));
    chk("t4_pend2",   64'(bus.pend_mask), 64'(0));
    chk("t4_hold_rd", 64'(bus.wb_rd), 64'(last_rd_exp));

    // Grant and reload of slot 0 on the same edge
    drive(REQ_ALU, 1'b1, 5'd7, 32'h77);
    @(negedge clk);
    drive(REQ_ALU, 1'b1, 5'd9, 32'h99);
    chk("t5_ready_grant", 64'(bus.req_ready[REQ_ALU]), 64'(1));
    chk("t5_pend_full",   64'(bus.pend_mask), 64'(32'h80));
    @(negedge clk);
    idle();
    chk("t5_wb_en",   64'(bus.wb_en), 64'(1));
    chk("t5_wb_rd",   64'(bus.wb_rd), 64'(7));
    chk("t5_wb_data", 64'(bus.wb_data), 64'(32'h77));
    chk("t5_pend",    64'(bus.pend_mask), 64'(32'h280));
    @(negedge clk);
    chk("t5_wb_en2",   64'(bus.wb_en), 64'(1));
    chk("t5_wb_rd2",   64'(bus.wb_rd), 64'(9));
    chk("t5_wb_data2", 64'(bus.wb_data), 64'(32'h99));
    chk("t5_pend2",    64'(bus.pend_mask), 64'(32'h200));
    @(negedge clk);
    chk("t5_done_wb_en", 64'(bus.wb_en), 64'(0));
    chk("t5_done_pend",  64'(bus.pend_mask), 64'(0));

    // ALU streams every cycle while the load slot is full
    drive(REQ_LSU, 1'b1, 5'd10, 32'hA0A0);
    drive(REQ_ALU, 1'b1, 5'd11, 32'hB0B0);
    @(negedge clk);
    drive(REQ_LSU, 1'b0, 5'd10, 32'hA0A0);
    nwrites     = 0;
    load_writes = 0;
    early       = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.wb_en) begin
        nwrites++;
        if (bus.wb_rd == 5'd10) begin
          load_writes++;
          if (nwrites <= 2) early = 1'b1;
        end
      end
    end
    chk("t3_stream_writes", 64'(nwrites), 64'(6));
    chk("t3_load_early",    64'(early), 64'(early_exp));
    chk("t3_pend10",        64'(bus.pend_mask[10]), 64'(pend10_exp));
    idle();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.wb_en && bus.wb_rd == 5'd10) load_writes++;
    end
    chk("t3_load_total", 64'(load_writes), 64'(1));
    chk("t3_done_wb_en", 64'(bus.wb_en), 64'(0));
    chk("t3_done_pend",  64'(bus.pend_mask), 64'(0));

    // Asynchronous reset with two full slots
    drive(REQ_ALU, 1'b1, 5'd4, 32'h44);
    drive(REQ_LSU, 1'b1, 5'd6, 32'h66);
    @(negedge clk);
    idle();
    chk("t6_pend_full", 64'(bus.pend_mask), 64'(32'h50));
    @(negedge clk);
    chk("t6_wb_en_pre", 64'(bus.wb_en), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_wb_en", 64'(bus.wb_en), 64'(0));
    chk("t6_rst_pend",  64'(bus.pend_mask), 64'(0));
    chk("t6_rst_wb_rd", 64'(bus.wb_rd), 64'(0));
    chk("t6_rst_ready", 64'(bus.req_ready), 64'(3'b111));
    @(negedge clk);
    rst    = 1'b1;
    writes = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.wb_en) writes++;
    end
    chk("t6_post_writes", 64'(writes), 64'(0));
    chk("t6_post_pend",   64'(bus.pend_mask), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
